// File: rtl/full_subtrator.sv
// Full subtractor with borrow-in/borrow-out: combinational A - B - Bin,
// plus a copy of the result registered on every rising clock edge.
module full_subtrator #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic [WIDTH-1:0] Diff_r,
    output logic             Bout_r
);

    // Ripple-borrow chain, LSB first; borrow leaves the MSB as Bout.
    always_comb begin
        logic borrow;
        Diff   = '0;
        borrow = Bin;
        for (int i = 0; i < WIDTH; i++) begin
            Diff[i] = A[i] ^ B[i] ^ borrow;
            borrow  = (~A[i] & B[i]) | (~A[i] & borrow) | (B[i] & borrow);
        end
        Bout = borrow;
    end

    // Stage boundary: registered copy, captured every cycle, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            Diff_r <= '0;
            Bout_r <= 1'b0;
        end else begin
            Diff_r <= Diff;
            Bout_r <= Bout;
        end
    end

endmodule

// File: tb/tb_full_subtrator.sv
// Self-checking bench for full_subtrator at WIDTH 1, 4 and 8.
module tb_full_subtrator;

    logic clk = 1'b0;
    logic clk_en = 1'b0;
    logic rst;

    logic       a1, b1, bin1;
    logic       diff1, bout1, diff_r1, bout_r1;
    logic [3:0] a4, b4;
    logic       bin4;
    logic [3:0] diff4, diff_r4;
    logic       bout4, bout_r4;
    logic [7:0] a8, b8;
    logic       bin8;
    logic [7:0] diff8, diff_r8;
    logic       bout8, bout_r8;

    int checks = 0;
    int errors = 0;

    always #5 if (clk_en) clk = ~clk;

    full_subtrator #(.WIDTH(1)) dut1 (
        .clk(clk), .rst(rst), .A(a1), .B(b1), .Bin(bin1),
        .Diff(diff1), .Bout(bout1), .Diff_r(diff_r1), .Bout_r(bout_r1)
    );
    full_subtrator #(.WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .A(a4), .B(b4), .Bin(bin4),
        .Diff(diff4), .Bout(bout4), .Diff_r(diff_r4), .Bout_r(bout_r4)
    );
    full_subtrator #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .A(a8), .B(b8), .Bin(bin8),
        .Diff(diff8), .Bout(bout8), .Diff_r(diff_r8), .Bout_r(bout_r8)
    );

    typedef struct {
        logic a, b, bin, diff, bout;
    } vec1_t;

    typedef struct {
        logic [3:0] a, b;
        logic       bin;
        logic [3:0] diff;
        logic       bout;
    } vec4_t;

    vec1_t tab1[8];
    vec4_t tab4[3];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: unsigned arithmetic, difference modulo 2^8, borrow when A < B + Bin.
    function automatic logic [8:0] model8(input int a, input int b, input int bin);
        int r;
        logic [8:0] res;
        r = a - b - bin;
        res[7:0] = 8'((r + 512) % 256);
        res[8]   = (a < b + bin);
        return res;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [8:0] exp8;

        tab1[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tab1[1] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        tab1[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
        tab1[3] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        tab1[4] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
        tab1[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tab1[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tab1[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        tab4[0] = '{4'd0,  4'd0,  1'b1, 4'hF, 1'b1};
        tab4[1] = '{4'd15, 4'd15, 1'b0, 4'h0, 1'b0};
        tab4[2] = '{4'd0,  4'd15, 1'b1, 4'h0, 1'b1};

        rst = 1'b1;
        a1 = 0; b1 = 0; bin1 = 0;
        a4 = 0; b4 = 0; bin4 = 0;
        a8 = 0; b8 = 0; bin8 = 0;
        #1;
        chk("reset diff_r1", diff_r1, 0);
        chk("reset bout_r1", bout_r1, 0);
        chk("reset diff_r8", diff_r8, 0);

        // Exhaustive WIDTH=1 sweep, clock idle, reset held
        for (int i = 0; i < 8; i++) begin
            a1 = tab1[i].a; b1 = tab1[i].b; bin1 = tab1[i].bin;
            #5;
            chk($sformatf("w1 diff %0d", i), diff1, tab1[i].diff);
            chk($sformatf("w1 bout %0d", i), bout1, tab1[i].bout);
            chk($sformatf("w1 diff_r %0d", i), diff_r1, 0);
            chk($sformatf("w1 bout_r %0d", i), bout_r1, 0);
            #5;
        end

        // Registered path: release reset, value appears one edge later
        clk_en = 1'b1;
        @(posedge clk);
        #1;
        chk("rst wins diff_r1", diff_r1, 0);
        @(negedge clk);
        rst = 1'b0;
        a1 = 0; b1 = 1; bin1 = 0;
        #1;
        chk("pre-edge diff_r1", diff_r1, 0);
        chk("pre-edge bout_r1", bout_r1, 0);
        @(posedge clk);
        #1;
        chk("post-edge diff_r1", diff_r1, 1);
        chk("post-edge bout_r1", bout_r1, 1);

        // Asynchronous reset between edges
        #2;
        rst = 1'b1;
        #1;
        chk("async diff_r1", diff_r1, 0);
        chk("async bout_r1", bout_r1, 0);
        chk("async diff1", diff1, 1);
        chk("async bout1", bout1, 1);
        @(posedge clk);
        #1;
        chk("held rst diff_r1", diff_r1, 0);
        chk("held rst bout_r1", bout_r1, 0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("reload diff_r1", diff_r1, 1);
        chk("reload bout_r1", bout_r1, 1);

        // WIDTH=4 boundaries, combinational then registered
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a4 = tab4[i].a; b4 = tab4[i].b; bin4 = tab4[i].bin;
            #1;
            chk($sformatf("w4 diff %0d", i), diff4, tab4[i].diff);
            chk($sformatf("w4 bout %0d", i), bout4, tab4[i].bout);
            @(posedge clk);
            #1;
            chk($sformatf("w4 diff_r %0d", i), diff_r4, tab4[i].diff);
            chk($sformatf("w4 bout_r %0d", i), bout_r4, tab4[i].bout);
        end

        // WIDTH=8 random against the arithmetic model
        for (int n = 0; n < 1000; n++) begin
            @(negedge clk);
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            bin8 = 1'($urandom_range(0, 1));
            exp8 = model8(int'(a8), int'(b8), int'(bin8));
            #1;
            chk("w8 diff", diff8, exp8[7:0]);
            chk("w8 bout", bout8, exp8[8]);
            @(posedge clk);
            #1;
            chk("w8 diff_r", diff_r8, exp8[7:0]);
            chk("w8 bout_r", bout_r8, exp8[8]);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
